// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART transmitter/receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmit FSM states; encodings 5..7 are unreachable
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    // Clock cycles per serial bit (integer division, truncating)
    function automatic int unsigned sclk_period(input int unsigned clock_hz,
                                                input int unsigned baud);
        return clock_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with combinational head read. Pushes while
//               full and pops while empty are ignored; pointers wrap
//               naturally because Depth is a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [Width-1:0]         din_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic [Width-1:0]         dout_o
);

    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(Depth);

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [Width-1:0] mem_q [Depth];

    logic w_push;
    logic w_pop;

    assign full_o  = (count_q == c_DEPTH);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    // Pointer and occupancy tracking; simultaneous push/pop keeps the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : FIFO-buffered UART transmitter. Frame = start bit, data LSB
//               first, optional even parity, 1 or 2 stop bits. The serial
//               line is a registered output that idles high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int BaudRate     = 9600,
    parameter int ClockFreqHz  = 10000000,
    parameter int ParityBit    = 0,
    parameter int DataBitsSize = 8,
    parameter int StopBitsSize = 1,
    parameter int FifoDepth    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_sig,
    output logic                          busy,
    output logic [$clog2(FifoDepth):0]    fifo_count
);

    localparam int unsigned c_SCLK      = sclk_period(ClockFreqHz, BaudRate);
    localparam logic [31:0] c_BIT_LAST  = 32'(c_SCLK - 1);
    localparam logic [31:0] c_STOP_LAST = 32'(StopBitsSize * c_SCLK - 1);
    localparam logic [2:0]  c_DATA_LAST = 3'(DataBitsSize - 1);
    localparam logic [7:0]  c_DATA_MASK = 8'((1 << DataBitsSize) - 1);

    uart_tx_state_e state_q, state_d;
    logic [31:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]     data_cnt_q, data_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic           tx_q, tx_d;

    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_dout;

    sync_fifo #(
        .Width (8),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_valid && tx_ready),
        .din_i   (tx_data),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .dout_o  (fifo_dout)
    );

    assign tx_ready = !fifo_full;
    assign tx_sig   = tx_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

    // Next-state logic: every bit lasts c_SCLK cycles, the stop period
    // StopBitsSize bits; the bit counter restarts on each bit boundary
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + 32'd1;
        data_cnt_d = data_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                tx_d      = 1'b1;
                if (!fifo_empty) begin
                    // Parity is frozen from the popped byte, masked to the
                    // transmitted width
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dout;
                    parity_d   = ^(fifo_dout & c_DATA_MASK);
                    data_cnt_d = '0;
                    tx_d       = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_cnt_q == c_BIT_LAST) begin
                    bit_cnt_d  = '0;
                    tx_d       = shift_q[0];
                    shift_d    = shift_q >> 1;
                    data_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (bit_cnt_q == c_BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (data_cnt_q == c_DATA_LAST) begin
                        if (ParityBit != 0) begin
                            tx_d    = parity_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        tx_d       = shift_q[0];
                        shift_d    = shift_q >> 1;
                        data_cnt_d = data_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_cnt_q == c_BIT_LAST) begin
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_cnt_q == c_STOP_LAST) begin
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                // Illegal encoding: park the line high and recover
                bit_cnt_d = '0;
                tx_d      = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset forces the line high at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            data_cnt_q <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            data_cnt_q <= data_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Two instances (8N1 and
//               7E2) share stimulus; a cycle-level reference model predicts
//               line level, occupancy, ready and busy from frame arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int c_CLK_HZ = 10000000;
    localparam int c_BAUD   = 1000000;
    localparam int c_SCLK   = 10;
    localparam int c_DEPTH  = 16;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;

    logic       ready_a, tx_a, busy_a;
    logic       ready_b, tx_b, busy_b;
    logic [4:0] cnt_a, cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .BaudRate(c_BAUD), .ClockFreqHz(c_CLK_HZ), .ParityBit(0),
        .DataBitsSize(8), .StopBitsSize(1), .FifoDepth(c_DEPTH)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_a), .tx_sig(tx_a), .busy(busy_a), .fifo_count(cnt_a)
    );

    uart_tx #(
        .BaudRate(c_BAUD), .ClockFreqHz(c_CLK_HZ), .ParityBit(1),
        .DataBitsSize(7), .StopBitsSize(2), .FifoDepth(c_DEPTH)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_b), .tx_sig(tx_b), .busy(busy_b), .fifo_count(cnt_b)
    );

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int dbits(input int i); return (i == 0) ? 8 : 7; endfunction
    function automatic int pbit (input int i); return (i == 0) ? 0 : 1; endfunction
    function automatic int sbits(input int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int flen (input int i);
        return (1 + dbits(i) + pbit(i) + sbits(i)) * c_SCLK;
    endfunction

    // Line level of each bit slot of a frame, slot 0 = start bit
    function automatic logic [11:0] frame_bits(input int i, input logic [7:0] b);
        logic [11:0] f;
        logic        p;
        int          n;
        f = '1;
        f[0] = 1'b0;
        p = 1'b0;
        for (int j = 0; j < dbits(i); j++) begin
            f[1 + j] = b[j];
            p = p ^ b[j];
        end
        n = 1 + dbits(i);
        if (pbit(i) != 0) f[n] = p;
        return f;
    endfunction

    logic [7:0]  mmem [2][64];
    int          wr   [2];
    int          rd   [2];
    bit          act  [2];
    int          k    [2];
    logic [11:0] fb   [2];

    // Per edge: a frame in flight advances; an idle transmitter takes the
    // head that was present before the edge; a push lands if not full
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wr[i] = 0; rd[i] = 0; act[i] = 1'b0; k[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int pre;
                pre = wr[i] - rd[i];
                if (act[i]) begin
                    k[i] = k[i] + 1;
                    if (k[i] == flen(i)) act[i] = 1'b0;
                end else if (pre > 0) begin
                    fb[i]  = frame_bits(i, mmem[i][rd[i] % 64]);
                    rd[i]  = rd[i] + 1;
                    act[i] = 1'b1;
                    k[i]   = 0;
                end
                if (tx_valid && (pre != c_DEPTH)) begin
                    mmem[i][wr[i] % 64] = tx_data;
                    wr[i] = wr[i] + 1;
                end
            end
        end
    end

    // Compare all outputs against the model every cycle on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                logic       e_tx;
                int         e_cnt;
                logic       g_tx, g_rdy, g_busy;
                logic [4:0] g_cnt;
                e_tx   = act[i] ? fb[i][k[i] / c_SCLK] : 1'b1;
                e_cnt  = wr[i] - rd[i];
                g_tx   = (i == 0) ? tx_a    : tx_b;
                g_rdy  = (i == 0) ? ready_a : ready_b;
                g_busy = (i == 0) ? busy_a  : busy_b;
                g_cnt  = (i == 0) ? cnt_a   : cnt_b;
                check($sformatf("tx_sig%0d", i), 32'(g_tx), 32'(e_tx));
                check($sformatf("fifo_count%0d", i), 32'(g_cnt), 32'(e_cnt));
                check($sformatf("tx_ready%0d", i), 32'(g_rdy), 32'(e_cnt != c_DEPTH));
                check($sformatf("busy%0d", i), 32'(g_busy), 32'(act[i] || (e_cnt > 0)));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Offer a byte until instance A accepts it; called and returns on a negedge
    task automatic send(input logic [7:0] b, input bit keep);
        int n;
        bit acc;
        tx_data  = b;
        tx_valid = 1'b1;
        n = 0;
        forever begin
            acc = ready_a;
            @(negedge clk);
            if (acc) break;
            n++;
            if (n > 5000) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tx_valid = 1'b0;
        while ((busy_a || busy_b) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy_a || busy_b), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_a"},    32'(tx_a),    32'd1);
        check({tag, "_tx_b"},    32'(tx_b),    32'd1);
        check({tag, "_ready_a"}, 32'(ready_a), 32'd1);
        check({tag, "_ready_b"}, 32'(ready_b), 32'd1);
        check({tag, "_busy_a"},  32'(busy_a),  32'd0);
        check({tag, "_busy_b"},  32'(busy_b),  32'd0);
        check({tag, "_cnt_a"},   32'(cnt_a),   32'd0);
        check({tag, "_cnt_b"},   32'(cnt_b),   32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single frames, including parity-1 and parity-0 bytes
        send(8'h41, 1'b0); wait_idle();
        send(8'h07, 1'b0); wait_idle();
        send(8'h03, 1'b0); wait_idle();

        // Burst of 17 with valid held high to overfill the FIFO
        for (int b = 0; b < 17; b++) send(8'(b), (b != 16));
        wait_idle();

        // All-ones data: line low only during start bits
        send(8'hFF, 1'b1);
        send(8'hFF, 1'b0);
        wait_idle();

        // Random bytes with random gaps and hold patterns
        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(8'($urandom), 1'($urandom_range(0, 1)));
        end
        wait_idle();

        // Reset roughly 35 cycles into a frame with a queued byte behind it
        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        repeat (34) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send(8'h5A, 1'b0);
        wait_idle();

        // More random traffic after recovery
        repeat (25) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(8'($urandom), 1'($urandom_range(0, 1)));
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
